mcast_copy_ctrl: RTL
====================

# mcast_copy_ctrl

Sequencing controller that expands one multicast/broadcast packet from input buffer A into a train of unicast copies for an 8x8 mesh node, one copy per output handshake. It owns the fan-out counter, the copy-mode flag and faulty-node (pg) skipping, so the router sees plain unicast traffic. It sits between IBUF_A and the route-compute stage.

## Interface
- `DATA_W`, default 32: payload width carried unchanged on every copy.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_vld`  in  1  packet offered by IBUF_A.
- `in_rdy`  out  1  controller can accept a packet.
- `in_type`  in  2  00 unicast, 01 column multicast (Y sweep), 10 row multicast (X sweep), 11 broadcast.
- `in_tgt`  in  6  target; bits [5:3] = Y, bits [2:0] = X.
- `in_data`  in  DATA_W  payload.
- `pg_en`  in  1  faulty node present.
- `pg_node`  in  6  faulty node coordinate.
- `out_vld`  out  1  copy valid.
- `out_rdy`  in  1  downstream accepts.
- `out_type`  out  2  00 on expanded copies; original type in pass-through.
- `out_tgt`  out  6  copy target.
- `out_data`  out  DATA_W  latched payload.
- `out_last`  out  1  final copy of the current packet.
- `cpy_mode`  out  1  high while more copies follow (equals `out_vld & ~out_last`).
- `drop_pg`  out  1  one-cycle pulse when a unicast to `pg_node` is discarded.
- `busy`  out  1  state is not IDLE.

## Operation
- FSM states: IDLE and SEND.
- IDLE: `in_rdy`=1. On `in_vld & in_rdy`, latch type, tgt, data, `pg_en` and `pg_node`. Mid-sequence changes on the `pg_*` inputs are ignored.
- Mode selection at accept:
  - Pass-through when `pg_en`=0, or when type is 00 and tgt != `pg_node`: one copy, tgt and type unchanged, `out_last`=1.
  - Drop when `pg_en`=1, type is 00 and tgt == `pg_node`: no output, `drop_pg` pulses the next cycle, stay IDLE.
  - Expand otherwise.
- Expand sequences, all in ascending order:
  - 01: {Y=0..7, X=tgt.X}.
  - 10: {Y=tgt.Y, X=0..7}.
  - 11: 0..63, X incrementing first and Y incrementing on X wrap 7→0.
- A candidate equal to latched `pg_node` is skipped with no bubble: the step advances by 2 positions.
- If `pg_node` is the first candidate, the sequence starts at the second.
- If `pg_node` is the final candidate, the penultimate copy carries `out_last`=1.
- Each expand sequence has at least 8 candidates, so at least 7 copies are always sent.
- SEND: on `out_vld & out_rdy`, either advance to the next target or, if `out_last`, go to IDLE.
- Coordinate arithmetic is 3-bit per axis with no carry from Y; end detection compares against 3'b111, never relies on overflow.

## Timing
- Reset values: `out_vld`=0, `out_tgt`=0, `out_type`=0, `out_data`=0, `out_last`=0, `cpy_mode`=0, `drop_pg`=0, `busy`=0, state IDLE, `in_rdy`=0 while `rst`=1.
- Latency: accept at cycle N gives `out_vld`=1 at N+1 with the first copy.
- Throughput: one copy per cycle while `out_rdy`=1.
- `in_rdy` is low from the cycle after accept until the cycle after the last-copy handshake. There is no same-cycle bypass, so a new accept is possible no earlier than the cycle after the last handshake.
- Output stability: while `out_vld & ~out_rdy`, all `out_*` and `cpy_mode` hold stable.
- Reset in SEND: the sequence is aborted and outputs return to reset values on the next edge.

## Structure
- Shared `mesh_pkg` holds:
  - `PKT_UNI`/`PKT_COL`/`PKT_ROW`/`PKT_BC` constants.
  - `COORD_W`=3.
  - An `fsm_t` enum (IDLE, SEND).
- One combinational sub-module, `mcast_tgt_step`. Inputs: type, base tgt, current tgt, `pg_node`, first flag. Outputs: next tgt (pg-skipped) and is_last. It is used both for first-target selection at accept and for advancing in SEND.

## Test plan
- `pg_en`=0, type 11, tgt=6'd5 → single copy: `out_tgt`=5, `out_type`=11, `out_last`=1, `cpy_mode`=0; `in_rdy` returns 2 cycles after accept with `out_rdy`=1.
- `pg_en`=1, `pg_node`=19 (Y2,X3), type 01, tgt X=3 → 7 copies with tgt 3,11,27,35,43,51,59; last=1 only on 59; type 00 on every copy.
- Same pg, type 10, tgt Y=2 → copies 16,17,18,20,21,22,23; back-to-back cycles with no bubble at the skip.
- `pg_en`=1, `pg_node`=63, type 11 → 63 copies with tgt 0..62; `out_last` on 62. Repeat with `pg_node`=0 → copies 1..63.
- `pg_en`=1, type 00, tgt=19=`pg_node` → no `out_vld`, one `drop_pg` pulse, `in_rdy` stays high.
- Random `out_rdy` stalls during a type 11 train, plus `rst` asserted at copy 10 → outputs held stable during stalls; reset clears all outputs next edge; a fresh packet after reset starts at tgt 0.

Source files
------------

// File: rtl/mesh_pkg.sv
// Shared mesh-node definitions: packet type encodings, coordinate widths and
// the copy-controller state enumeration.
package mesh_pkg;

  localparam int COORD_W = 3;
  localparam int TGT_W   = 2 * COORD_W;

  localparam logic [1:0] PKT_UNI = 2'b00;
  localparam logic [1:0] PKT_COL = 2'b01;
  localparam logic [1:0] PKT_ROW = 2'b10;
  localparam logic [1:0] PKT_BC  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } fsm_t;

endpackage

// File: rtl/mcast_tgt_step.sv
// Combinational target stepper: picks the next copy target of an expand
// sequence (skipping the faulty node) and flags whether it is the final copy.
module mcast_tgt_step
  import mesh_pkg::*;
(
  input  logic [1:0]       typ,
  input  logic [TGT_W-1:0] base_tgt,
  input  logic [TGT_W-1:0] cur_tgt,
  input  logic [TGT_W-1:0] pg_node,
  input  logic             first,
  output logic [TGT_W-1:0] nxt_tgt,
  output logic             is_last
);

  // Per-axis 3-bit increments; Y never receives a carry out of itself.
  function automatic logic [TGT_W-1:0] step_f(input logic [1:0] t, input logic [TGT_W-1:0] c);
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
    y = c[TGT_W-1 -: COORD_W];
    x = c[COORD_W-1:0];
    case (t)
      PKT_COL: y = y + 3'd1;
      PKT_ROW: x = x + 3'd1;
      PKT_BC: begin
        if (x == 3'b111) begin
          x = 3'd0;
          y = y + 3'd1;
        end else begin
          x = x + 3'd1;
        end
      end
      default: x = x;
    endcase
    return {y, x};
  endfunction

  function automatic logic [TGT_W-1:0] start_f(input logic [1:0] t, input logic [TGT_W-1:0] b);
    logic [TGT_W-1:0] s;
    case (t)
      PKT_COL: s = {3'd0, b[COORD_W-1:0]};
      PKT_ROW: s = {b[TGT_W-1 -: COORD_W], 3'd0};
      PKT_BC:  s = 6'd0;
      default: s = b;
    endcase
    return s;
  endfunction

  function automatic logic is_end_f(input logic [1:0] t, input logic [TGT_W-1:0] c);
    logic e;
    case (t)
      PKT_COL: e = (c[TGT_W-1 -: COORD_W] == 3'b111);
      PKT_ROW: e = (c[COORD_W-1:0] == 3'b111);
      PKT_BC:  e = (c[TGT_W-1 -: COORD_W] == 3'b111) && (c[COORD_W-1:0] == 3'b111);
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  logic [TGT_W-1:0] cand_s;
  logic [TGT_W-1:0] peek_s;

  assign cand_s  = first ? start_f(typ, base_tgt) : step_f(typ, cur_tgt);
  assign nxt_tgt = (cand_s == pg_node) ? step_f(typ, cand_s) : cand_s;
  // A faulty final candidate makes the penultimate copy the last one.
  assign peek_s  = step_f(typ, nxt_tgt);
  assign is_last = is_end_f(typ, nxt_tgt) || (is_end_f(typ, peek_s) && (peek_s == pg_node));

endmodule

// File: rtl/mcast_copy_ctrl.sv
// Expands one multicast/broadcast packet into a train of unicast copies,
// skipping the faulty node, with pass-through and drop for plain unicasts.
module mcast_copy_ctrl
  import mesh_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [1:0]        in_type,
  input  logic [TGT_W-1:0]  in_tgt,
  input  logic [DATA_W-1:0] in_data,
  input  logic              pg_en,
  input  logic [TGT_W-1:0]  pg_node,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [1:0]        out_type,
  output logic [TGT_W-1:0]  out_tgt,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              cpy_mode,
  output logic              drop_pg,
  output logic              busy
);

  fsm_t              state_r, state_nxt_s;
  logic [1:0]        typ_r;
  logic [TGT_W-1:0]  base_r;
  logic [TGT_W-1:0]  pg_r;
  logic [DATA_W-1:0] data_r;
  logic              vld_r, last_r, cpy_r, drop_r;
  logic [1:0]        otype_r;
  logic [TGT_W-1:0]  otgt_r;

  logic              vld_nxt_s, last_nxt_s, drop_nxt_s, accept_s;
  logic [1:0]        otype_nxt_s;
  logic [TGT_W-1:0]  otgt_nxt_s;
  logic              first_s;
  logic [1:0]        step_typ_s;
  logic [TGT_W-1:0]  step_base_s, step_pg_s, step_nxt_s;
  logic              step_last_s;

  assign in_rdy   = (state_r == IDLE) && !rst;
  assign accept_s = in_vld && in_rdy;
  assign first_s  = (state_r == IDLE);

  // In IDLE the stepper sees the live inputs so the first copy is ready at N+1.
  assign step_typ_s  = first_s ? in_type : typ_r;
  assign step_base_s = first_s ? in_tgt  : base_r;
  assign step_pg_s   = first_s ? pg_node : pg_r;

  mcast_tgt_step u_step (
    .typ      (step_typ_s),
    .base_tgt (step_base_s),
    .cur_tgt  (otgt_r),
    .pg_node  (step_pg_s),
    .first    (first_s),
    .nxt_tgt  (step_nxt_s),
    .is_last  (step_last_s)
  );

  // Next-state and next-output selection.
  always_comb begin
    state_nxt_s = state_r;
    vld_nxt_s   = vld_r;
    last_nxt_s  = last_r;
    otype_nxt_s = otype_r;
    otgt_nxt_s  = otgt_r;
    drop_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        vld_nxt_s = 1'b0;
        if (accept_s) begin
          if (!pg_en || ((in_type == PKT_UNI) && (in_tgt != pg_node))) begin
            vld_nxt_s   = 1'b1;
            otgt_nxt_s  = in_tgt;
            otype_nxt_s = in_type;
            last_nxt_s  = 1'b1;
            state_nxt_s = SEND;
          end else if (in_type == PKT_UNI) begin
            drop_nxt_s = 1'b1;
          end else begin
            vld_nxt_s   = 1'b1;
            otgt_nxt_s  = step_nxt_s;
            otype_nxt_s = PKT_UNI;
            last_nxt_s  = step_last_s;
            state_nxt_s = SEND;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEND: begin
        if (out_rdy) begin
          if (last_r) begin
            vld_nxt_s   = 1'b0;
            state_nxt_s = IDLE;
          end else begin
            otgt_nxt_s = step_nxt_s;
            last_nxt_s = step_last_s;
          end
        end else begin
          state_nxt_s = SEND;
        end
      end
      default: begin
        vld_nxt_s   = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, packet latch and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      typ_r   <= 2'd0;
      base_r  <= 6'd0;
      pg_r    <= 6'd0;
      data_r  <= '0;
      vld_r   <= 1'b0;
      last_r  <= 1'b0;
      cpy_r   <= 1'b0;
      drop_r  <= 1'b0;
      otype_r <= 2'd0;
      otgt_r  <= 6'd0;
    end else begin
      state_r <= state_nxt_s;
      vld_r   <= vld_nxt_s;
      last_r  <= last_nxt_s;
      cpy_r   <= vld_nxt_s && !last_nxt_s;
      drop_r  <= drop_nxt_s;
      otype_r <= otype_nxt_s;
      otgt_r  <= otgt_nxt_s;
      if (accept_s) begin
        typ_r  <= in_type;
        base_r <= in_tgt;
        pg_r   <= pg_node;
        data_r <= in_data;
      end
    end
  end

  assign out_vld  = vld_r;
  assign out_last = last_r;
  assign cpy_mode = cpy_r;
  assign drop_pg  = drop_r;
  assign out_type = otype_r;
  assign out_tgt  = otgt_r;
  assign out_data = data_r;
  assign busy     = (state_r != IDLE);

endmodule
